gf_mul_arbiter: RTL and testbench

Shares one external, fully pipelined GF(2^255-19) modular multiplier among NUM_REQ requesters, such as the scalar-multiplication point-add/double engine and the projective-to-affine reduction/inversion engine. It grants requests round-robin and launches one multiply per cycle. It tracks each in-flight operation's requester ID in a tag pipeline and routes each result back to the requester that issued it.

---
 rtl/gf_pkg.sv | 19 +
 rtl/gf_mul_arbiter_if.sv | 36 +++
 rtl/gf_rr_arbiter.sv | 72 +++++++
 rtl/gf_mul_arbiter.sv | 141 ++++++++++++++
 tb/tb_gf_mul_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// Shared field-element types and constants for the GF(2^255-19) multiplier arbiter.
package gf_pkg;

    localparam int FE_W = 255;

    typedef logic [FE_W-1:0] fe_t;

    // 2^255 - 19: every bit set except the low five, which hold 5'b01101.
    localparam fe_t P_25519 = {{(FE_W-5){1'b1}}, 5'b01101};

    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/gf_mul_arbiter_if.sv
// Requester and multiplier signal bundle for gf_mul_arbiter.
// The arbiter connects through the slave modport. The master modport is the
// requesters-plus-multiplier side.
interface gf_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 255
);

    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ*WIDTH-1:0] i_req_a;
    logic [NUM_REQ*WIDTH-1:0] i_req_b;

    logic                     o_mul_valid;
    logic [WIDTH-1:0]         o_mul_a;
    logic [WIDTH-1:0]         o_mul_b;
    logic                     i_mul_valid;
    logic [WIDTH-1:0]         i_mul_data;

    logic [NUM_REQ-1:0]       o_rsp_valid;
    logic [WIDTH-1:0]         o_rsp_data;
    logic                     o_err;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_mul_valid, i_mul_data,
        output o_req_ready, o_mul_valid, o_mul_a, o_mul_b,
               o_rsp_valid, o_rsp_data, o_err
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_mul_valid, i_mul_data,
        input  o_req_ready, o_mul_valid, o_mul_a, o_mul_b,
               o_rsp_valid, o_rsp_data, o_err
    );

endinterface

// File: rtl/gf_rr_arbiter.sv
// Round-robin grant generator that owns the rotation pointer.
// Optional macro GF_ARB_PRIO0_EN gives requester 0 absolute priority.
// While requester 0 is requesting, the pointer is frozen.
module gf_rr_arbiter
    import gf_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_gnt_vld,
    output logic [$clog2(NUM_REQ)-1:0] o_gnt_id
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [SUM_W-1:0]   idx_sum;
    logic               prio_hit;
    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_id;

    // Scan from the pointer upward (mod NUM_REQ) for the first request; no grant in reset.
    always_comb begin
        ptr_d    = ptr_q;
        idx_sum  = '0;
        prio_hit = 1'b0;
        gnt_vld  = 1'b0;
        gnt_id   = '0;
`ifdef GF_ARB_PRIO0_EN
        prio_hit = i_req[0];
`endif
        if (prio_hit) begin
            gnt_vld = 1'b1;
            gnt_id  = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_sum = {1'b0, ptr_q} + SUM_W'(i);
                if (idx_sum >= SUM_W'(NUM_REQ)) begin
                    idx_sum = idx_sum - SUM_W'(NUM_REQ);
                end
                if (!gnt_vld && i_req[idx_sum[PTR_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx_sum[PTR_W-1:0];
                end
            end
            if (gnt_vld) begin
                ptr_d = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + PTR_W'(1);
            end
        end
        if (i_rst) begin
            gnt_vld = 1'b0;
        end
    end

    assign o_gnt_vld = gnt_vld;
    assign o_gnt_id  = gnt_id;
    assign o_gnt     = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;

    // Pointer register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gf_mul_arbiter.sv
// Shares one pipelined GF(2^255-19) multiplier among NUM_REQ requesters.
// Grants are round-robin, and at most one multiply is launched per cycle.
// A tag pipe that matches the multiplier latency carries each operation's requester id.
// The id steers the result back to the requester that issued it.
// Optional macro GF_ARB_PRIO0_EN (in gf_rr_arbiter) gives requester 0 absolute priority.
module gf_mul_arbiter
    import gf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 8,
    parameter int WIDTH   = FE_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    gf_mul_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_id;

    logic [WIDTH-1:0]   req_a_arr [NUM_REQ];
    logic [WIDTH-1:0]   req_b_arr [NUM_REQ];

    logic               mul_valid_q, mul_valid_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [ID_W-1:0]    mul_id_q, mul_id_d;

    mul_tag_t           tag_q [MUL_LAT];
    mul_tag_t           tag_d [MUL_LAT];
    mul_tag_t           tail;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    gf_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (bus.i_req_valid),
        .o_gnt     (gnt),
        .o_gnt_vld (gnt_vld),
        .o_gnt_id  (gnt_id)
    );

    assign bus.o_req_ready = gnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_a_arr[g] = bus.i_req_a[g*WIDTH +: WIDTH];
        assign req_b_arr[g] = bus.i_req_b[g*WIDTH +: WIDTH];
    end

    // Capture the granted operands; operands hold their last value between launches.
    always_comb begin
        mul_valid_d = gnt_vld;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_id_d    = mul_id_q;
        if (gnt_vld) begin
            mul_a_d  = req_a_arr[gnt_id];
            mul_b_d  = req_b_arr[gnt_id];
            mul_id_d = gnt_id;
        end
    end

    // Launch registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_id_q    <= '0;
        end else begin
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_id_q    <= mul_id_d;
        end
    end

    // Tag pipe shifts every cycle so its tail lines up with the multiplier result strobe.
    always_comb begin
        tag_d[0] = '{vld: mul_valid_q, id: TAG_ID_W'(mul_id_q)};
        for (int i = 1; i < MUL_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipe registers; reset drops everything in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tail = tag_q[MUL_LAT-1];

    // Route a matched result to its requester; a tag/strobe disagreement latches the error.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (tail.vld && bus.i_mul_valid) begin
            rsp_valid_d = NUM_REQ'(1) << tail.id;
            rsp_data_d  = bus.i_mul_data;
        end
        if (tail.vld != bus.i_mul_valid) begin
            err_d = 1'b1;
        end
    end

    // Response and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_mul_valid = mul_valid_q;
    assign bus.o_mul_a     = mul_a_q;
    assign bus.o_mul_b     = mul_b_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Directed bench for gf_mul_arbiter.
// It contains a behavioural pipelined multiplier and a response scoreboard.
module tb_gf_mul_arbiter;
    import gf_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 8;
    localparam int W    = FE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf_mul_arbiter_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus ();

    gf_mul_arbiter #(.NUM_REQ(NREQ), .MUL_LAT(LAT), .WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int  id;
        fe_t data;
        int  due;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    fe_t cur_a [NREQ];
    fe_t cur_b [NREQ];

    function automatic fe_t gf_mul(input fe_t a, input fe_t b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, P_25519};
        return p[W-1:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return {2'b00, r[252:0]};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural multiplier: fixed LAT-cycle pipeline, reset together with the DUT.
    logic mv [LAT];
    fe_t  md [LAT];
    logic kill = 1'b0;
    logic spur = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                mv[i] <= 1'b0;
                md[i] <= '0;
            end
        end else begin
            mv[0] <= bus.o_mul_valid;
            md[0] <= gf_mul(bus.o_mul_a, bus.o_mul_b);
            for (int i = 1; i < LAT; i++) begin
                mv[i] <= mv[i-1];
                md[i] <= md[i-1];
            end
        end
    end

    assign bus.i_mul_valid = (mv[LAT-1] & ~kill) | spur;
    assign bus.i_mul_data  = md[LAT-1];

    // Response monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (|bus.o_rsp_valid) begin
            chk("rsp_unexpected", W'(sb.size() > 0), W'(1));
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rsp_onehot", W'(bus.o_rsp_valid), W'(NREQ'(1) << mon_e.id));
                chk("rsp_data", bus.o_rsp_data, mon_e.data);
                chk("rsp_latency", W'(cyc), W'(mon_e.due));
            end
        end
    end

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            bus.i_req_a[k*W +: W] = cur_a[k];
            bus.i_req_b[k*W +: W] = cur_b[k];
        end
    endtask

    task automatic step(input logic [NREQ-1:0] vld, input logic [NREQ-1:0] exp_rdy,
                        input bit push, input string tag);
        @(negedge clk);
        bus.i_req_valid = vld;
        drive_ops();
        #1;
        chk(tag, W'(bus.o_req_ready), W'(exp_rdy));
        for (int k = 0; k < NREQ; k++) begin
            if (exp_rdy[k]) begin
                if (push) sb.push_back('{id: k, data: gf_mul(cur_a[k], cur_b[k]), due: cyc + LAT + 2});
                cur_a[k] = rand_fe();
                cur_b[k] = rand_fe();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        @(negedge clk);
        bus.i_req_valid = '0;
        for (int i = 0; i < 4*LAT; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", W'(sb.size()), W'(0));
    endtask

    int  t0;
    bit  seen;

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            cur_a[k] = rand_fe();
            cur_b[k] = rand_fe();
        end
        bus.i_req_valid = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;

        // Reset and idle.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mul_valid", W'(bus.o_mul_valid), W'(0));
        chk("rst_err", W'(bus.o_err), W'(0));
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outs", W'({bus.o_mul_valid, bus.o_rsp_valid, bus.o_err, bus.o_req_ready}), W'(0));
        end
        chk("idle_mul_a", bus.o_mul_a, W'(0));
        chk("idle_mul_b", bus.o_mul_b, W'(0));
        chk("idle_rsp_data", bus.o_rsp_data, W'(0));

        // Single request from requester 1: 3 * 5.
        cur_a[1] = W'(3);
        cur_b[1] = W'(5);
        step(4'b0010, 4'b0010, 1'b1, "single_gnt");
        t0 = cyc;
        @(negedge clk);
        bus.i_req_valid = '0;
        chk("single_launch_v", W'(bus.o_mul_valid), W'(1));
        chk("single_launch_a", bus.o_mul_a, W'(3));
        chk("single_launch_b", bus.o_mul_b, W'(5));
        while (cyc < t0 + LAT + 2) @(negedge clk);
        chk("single_rsp_v", W'(bus.o_rsp_valid), W'(4'b0010));
        chk("single_rsp_d", bus.o_rsp_data, W'(15));
        drain();

        // All four requesters continuously valid for 8 cycles; first op of 0 and 2 is (p-1)^2.
        do_reset();
        cur_a[0] = P_25519 - W'(1);
        cur_b[0] = P_25519 - W'(1);
        cur_a[2] = P_25519 - W'(1);
        cur_b[2] = P_25519 - W'(1);
        for (int i = 0; i < 8; i++) begin
`ifdef GF_ARB_PRIO0_EN
            step(4'b1111, 4'b0001, 1'b1, "rr4_gnt");
`else
            step(4'b1111, 4'b0001 << (i % 4), 1'b1, "rr4_gnt");
`endif
            if (i == 0) t0 = cyc;
        end
        @(negedge clk);
        bus.i_req_valid = '0;
        while (cyc < t0 + LAT + 2) @(negedge clk);
        chk("pm1_sq_v", W'(bus.o_rsp_valid), W'(4'b0001));
        chk("pm1_sq_d", bus.o_rsp_data, W'(1));
        drain();

        // Wrap: move ptr to 3, then requesters 2 and 3 -> 3 then 2; ptr ends at 3.
        do_reset();
        step(4'b0100, 4'b0100, 1'b1, "wrap_set_ptr");
        step(4'b1100, 4'b1000, 1'b1, "wrap_gnt3");
        step(4'b1100, 4'b0100, 1'b1, "wrap_gnt2");
        step(4'b1110, 4'b1000, 1'b1, "wrap_ptr_end");
        drain();

        // Dropped strobe, then spurious strobe.
        do_reset();
        step(4'b0010, 4'b0010, 1'b0, "err_gnt");
        @(negedge clk);
        bus.i_req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 3*LAT; i++) begin
            if (mv[LAT-1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("err_result_seen", W'(seen), W'(1));
        chk("err_before", W'(bus.o_err), W'(0));
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("err_drop", W'(bus.o_err), W'(1));
        chk("err_drop_no_rsp", W'(bus.o_rsp_valid), W'(0));
        repeat (3) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("err_spur", W'(bus.o_err), W'(1));
        chk("err_spur_no_rsp", W'(bus.o_rsp_valid), W'(0));
        repeat (5) @(negedge clk);
        chk("err_sticky", W'(bus.o_err), W'(1));

        // Reset with five operations in flight.
        do_reset();
        chk("err_cleared", W'(bus.o_err), W'(0));
        step(4'b1110, 4'b0010, 1'b0, "fly_gnt");
        step(4'b1110, 4'b0100, 1'b0, "fly_gnt");
        step(4'b1110, 4'b1000, 1'b0, "fly_gnt");
        step(4'b1110, 4'b0010, 1'b0, "fly_gnt");
        step(4'b1110, 4'b0100, 1'b0, "fly_gnt");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", W'(bus.o_req_ready), W'(0));
        @(negedge clk);
        chk("rst_ready_hold", W'(bus.o_req_ready), W'(0));
        rst = 1'b0;
        bus.i_req_valid = '0;
        sb.delete();
        repeat (LAT + 6) begin
            @(negedge clk);
            chk("fly_quiet", W'({bus.o_rsp_valid, bus.o_err, bus.o_mul_valid}), W'(0));
        end

        // Requesters 0 and 2 held valid.
        do_reset();
`ifdef GF_ARB_PRIO0_EN
        step(4'b0101, 4'b0001, 1'b1, "prio_gnt0");
        step(4'b0101, 4'b0001, 1'b1, "prio_gnt0");
        step(4'b0101, 4'b0001, 1'b1, "prio_gnt0");
        step(4'b0100, 4'b0100, 1'b1, "prio_gnt2");
`else
        step(4'b0101, 4'b0001, 1'b1, "rr02_gnt0");
        step(4'b0101, 4'b0100, 1'b1, "rr02_gnt2");
        step(4'b0101, 4'b0001, 1'b1, "rr02_gnt0b");
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
